// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard / stall controller. Produces the write-enable (stall_n)
//   and bubble (flush) controls for the IF/ID, ID/EX, EX/MEM and MEM/WB
//   pipeline registers.
//   - Load-use: EX load whose destination feeds an ID source -> one bubble.
//   - Taken branch resolved in ID -> flush IF/ID.
//   - Unacknowledged data-memory access -> freeze the front of the pipe and
//     bubble MEM/WB until the ack arrives.
//   - HLT in ID -> drain EX/MEM/WB for DRAIN_CYC cycles, then halt.
//   - Memory wait of TIMEOUT cycles -> sticky error.
//   Ports:
//     clk, rst_n                   clock, async active-low reset
//     id_rs_reg/id_rt_reg          ID source registers
//     id_uses_rs/id_uses_rt        ID source register valid
//     id_halt, id_branch_taken     HLT / taken branch in ID
//     ex_rd, ex_mem_read,
//     ex_WriteReg                  EX destination and load/writeback flags
//     mem_req, mem_ack             MEM access in flight / completes
//     if_stall_n .. mem_wb_flush   pipeline register controls
//     halted, mem_timeout          status
//     stall_count                  saturating count of IF stall cycles
module hazard_ctrl #(
   parameter int DRAIN_CYC = 3,
   parameter int TIMEOUT   = 64,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       id_rs_reg,
   input  logic [3:0]       id_rt_reg,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_halt,
   input  logic             id_branch_taken,
   input  logic [3:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_WriteReg,
   input  logic             mem_req,
   input  logic             mem_ack,
   output logic             if_stall_n,
   output logic             if_id_flush,
   output logic             id_ex_stall_n,
   output logic             id_ex_flush,
   output logic             ex_mem_stall_n,
   output logic             mem_wb_flush,
   output logic             halted,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count
);

   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED, ERROR} state_t;

   state_t            state_q;
   logic [WW-1:0]     wait_cnt_q;
   logic [DW-1:0]     drain_cnt_q;
   logic [CNT_W-1:0]  stall_cnt_q;

   logic mem_wait;
   logic load_use;
   logic active;

   assign mem_wait = mem_req & ~mem_ack;
   // r0 is hardwired zero, so a load targeting it never creates a dependency
   assign load_use = ex_mem_read & ex_WriteReg & (ex_rd != 4'd0) &
                     ((id_uses_rs & (id_rs_reg == ex_rd)) |
                      (id_uses_rt & (id_rt_reg == ex_rd)));
   assign active   = (state_q == RUN) || (state_q == DRAIN);

   // Pipeline controls. Priority: mem_wait > load_use > halt/drain > branch.
   always_comb begin
      if_stall_n     = 1'b1;
      id_ex_stall_n  = 1'b1;
      ex_mem_stall_n = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      mem_wb_flush   = 1'b0;
      if (active) begin
         if (mem_wait) begin
            // freeze everything upstream of MEM, drop a bubble into WB
            if_stall_n     = 1'b0;
            id_ex_stall_n  = 1'b0;
            ex_mem_stall_n = 1'b0;
            mem_wb_flush   = 1'b1;
         end else if (load_use || (state_q == DRAIN) || id_halt) begin
            // hold IF/ID and feed a bubble into EX; branches are ignored while draining
            if_stall_n  = 1'b0;
            id_ex_flush = 1'b1;
         end else if (id_branch_taken) begin
            if_id_flush = 1'b1;
         end
      end else begin
         if_stall_n     = 1'b0;
         id_ex_stall_n  = 1'b0;
         ex_mem_stall_n = 1'b0;
      end
   end

   assign halted      = (state_q == HALTED);
   assign mem_timeout = (state_q == ERROR);
   assign stall_count = stall_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         drain_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else if (active) begin
         wait_cnt_q <= mem_wait ? wait_cnt_q + 1'b1 : '0;
         if (!if_stall_n && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_q <= stall_cnt_q + 1'b1;
         // an ack on the last cycle clears mem_wait, so it beats the timeout
         if (mem_wait && (wait_cnt_q == WAIT_LAST)) begin
            state_q <= ERROR;
         end else if (!mem_wait) begin
            if (state_q == RUN) begin
               if (!load_use && id_halt) begin
                  state_q     <= DRAIN;
                  drain_cnt_q <= DRAIN_LOAD;
               end
            end else if (drain_cnt_q == '0) begin
               state_q <= HALTED;
            end else begin
               drain_cnt_q <= drain_cnt_q - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] id_rs_reg, id_rt_reg, ex_rd;
   logic       id_uses_rs, id_uses_rt, id_halt, id_branch_taken;
   logic       ex_mem_read, ex_WriteReg, mem_req, mem_ack;

   logic        if_stall_n, if_id_flush, id_ex_stall_n, id_ex_flush;
   logic        ex_mem_stall_n, mem_wb_flush, halted, mem_timeout;
   logic [15:0] stall_count;

   logic       if_stall_n4, if_id_flush4, id_ex_stall_n4, id_ex_flush4;
   logic       ex_mem_stall_n4, mem_wb_flush4, halted4, mem_timeout4;
   logic [3:0] stall_count4;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_cnt;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs_reg(id_rs_reg), .id_rt_reg(id_rt_reg),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_halt(id_halt), .id_branch_taken(id_branch_taken),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_WriteReg(ex_WriteReg),
      .mem_req(mem_req), .mem_ack(mem_ack),
      .if_stall_n(if_stall_n), .if_id_flush(if_id_flush),
      .id_ex_stall_n(id_ex_stall_n), .id_ex_flush(id_ex_flush),
      .ex_mem_stall_n(ex_mem_stall_n), .mem_wb_flush(mem_wb_flush),
      .halted(halted), .mem_timeout(mem_timeout), .stall_count(stall_count)
   );

   hazard_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .id_rs_reg(id_rs_reg), .id_rt_reg(id_rt_reg),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_halt(id_halt), .id_branch_taken(id_branch_taken),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_WriteReg(ex_WriteReg),
      .mem_req(mem_req), .mem_ack(mem_ack),
      .if_stall_n(if_stall_n4), .if_id_flush(if_id_flush4),
      .id_ex_stall_n(id_ex_stall_n4), .id_ex_flush(id_ex_flush4),
      .ex_mem_stall_n(ex_mem_stall_n4), .mem_wb_flush(mem_wb_flush4),
      .halted(halted4), .mem_timeout(mem_timeout4), .stall_count(stall_count4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic idle();
      id_rs_reg = 0; id_rt_reg = 0; ex_rd = 0;
      id_uses_rs = 0; id_uses_rt = 0; id_halt = 0; id_branch_taken = 0;
      ex_mem_read = 0; ex_WriteReg = 0; mem_req = 0; mem_ack = 0;
   endtask

   task automatic set_lu(input logic [3:0] rd);
      ex_mem_read = 1; ex_WriteReg = 1; ex_rd = rd; id_rs_reg = rd; id_uses_rs = 1;
   endtask

   // expected: everything at its reset value (inputs idle)
   task automatic chk_rst(input string tag);
      chk({tag, "_if_stall_n"}, if_stall_n, 1);
      chk({tag, "_id_ex_stall_n"}, id_ex_stall_n, 1);
      chk({tag, "_ex_mem_stall_n"}, ex_mem_stall_n, 1);
      chk({tag, "_flushes"}, {if_id_flush, id_ex_flush, mem_wb_flush}, 0);
      chk({tag, "_halted"}, halted, 0);
      chk({tag, "_mem_timeout"}, mem_timeout, 0);
      chk({tag, "_stall_count"}, stall_count, 0);
   endtask

   task automatic do_rst();
      idle();
      #2 rst_n = 1'b0;
      #1 chk_rst("async_rst");
      @(negedge clk) rst_n = 1'b1;
      exp_cnt = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rst_n = 1'b0;
      exp_cnt = 0;
      #12;
      chk_rst("reset");
      chk("reset4_stalls", {if_stall_n4, id_ex_stall_n4, ex_mem_stall_n4}, 3'b111);
      chk("reset4_flush", {if_id_flush4, id_ex_flush4, mem_wb_flush4}, 0);
      chk("reset4_status", {halted4, mem_timeout4, stall_count4}, 0);
      @(negedge clk) rst_n = 1'b1;

      // ---- load-use ----
      @(negedge clk); set_lu(4'd5);
      #1 chk("lu_if_stall_n", if_stall_n, 0);
      chk("lu_id_ex_flush", id_ex_flush, 1);
      chk("lu_ex_mem_stall_n", ex_mem_stall_n, 1);
      chk("lu_id_ex_stall_n", id_ex_stall_n, 1);
      exp_cnt++;
      @(negedge clk); idle();
      #1 chk("lu_clear", {if_stall_n, id_ex_flush}, 2'b10);
      chk("lu_cnt", stall_count, exp_cnt);
      @(negedge clk); set_lu(4'd0);
      #1 chk("lu_r0", {if_stall_n, id_ex_flush}, 2'b10);
      @(negedge clk); idle();
      ex_mem_read = 1; ex_WriteReg = 1; ex_rd = 9; id_rt_reg = 9; id_uses_rt = 1;
      #1 chk("lu_rt", {if_stall_n, id_ex_flush}, 2'b01);
      exp_cnt++;
      @(negedge clk); id_uses_rt = 0;
      #1 chk("lu_rt_unused", {if_stall_n, id_ex_flush}, 2'b10);
      @(negedge clk); ex_WriteReg = 0; id_uses_rt = 1;
      #1 chk("lu_no_wr", {if_stall_n, id_ex_flush}, 2'b10);
      @(negedge clk); idle();
      #1 chk("lu_cnt2", stall_count, exp_cnt);

      // ---- branch under memory stall ----
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk); id_branch_taken = 1; mem_req = 1; mem_ack = 0;
         #1 chk($sformatf("br_wait%0d_if_id_flush", i), if_id_flush, 0);
         chk($sformatf("br_wait%0d_mem_wb_flush", i), mem_wb_flush, 1);
         chk($sformatf("br_wait%0d_stalls", i), {if_stall_n, id_ex_stall_n, ex_mem_stall_n}, 0);
         exp_cnt++;
      end
      @(negedge clk); mem_ack = 1;
      #1 chk("br_ack_if_id_flush", if_id_flush, 1);
      chk("br_ack_mem_wb_flush", mem_wb_flush, 0);
      chk("br_ack_if_stall_n", if_stall_n, 1);
      @(negedge clk); idle();
      #1 chk("br_cnt", stall_count, exp_cnt);

      // ---- timeout: ack on cycle 64 wins, then a full wait errors ----
      @(negedge clk); mem_req = 1; mem_ack = 0;
      repeat (63) @(negedge clk);
      exp_cnt += 63;
      mem_ack = 1;
      #1 chk("to_ack_if_stall_n", if_stall_n, 1);
      @(negedge clk); mem_ack = 0;
      #1 chk("to_ack_no_err", mem_timeout, 0);
      repeat (63) @(negedge clk);
      exp_cnt += 63;
      #1 chk("to_63_no_err", mem_timeout, 0);
      @(negedge clk);
      exp_cnt++;
      #1 chk("to_err", mem_timeout, 1);
      chk("to_err_stalls", {if_stall_n, id_ex_stall_n, ex_mem_stall_n}, 0);
      chk("to_err_flush", {if_id_flush, id_ex_flush, mem_wb_flush}, 0);
      chk("to_err_halted", halted, 0);
      @(negedge clk); idle(); set_lu(4'd3);
      repeat (3) @(negedge clk);
      #1 chk("to_sticky", mem_timeout, 1);
      chk("to_cnt_frozen", stall_count, exp_cnt);
      do_rst();

      // ---- halt drain ----
      @(negedge clk); id_halt = 1;
      #1 chk("halt_ctrl", {if_stall_n, id_ex_flush, halted}, 3'b010);
      exp_cnt++;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk); id_halt = 0; id_branch_taken = (i == 1);
         #1 chk($sformatf("drain%0d_halted", i), halted, 0);
         chk($sformatf("drain%0d_ctrl", i), {if_stall_n, id_ex_flush, if_id_flush}, 3'b010);
         chk($sformatf("drain%0d_cnt", i), stall_count, exp_cnt);
         exp_cnt++;
      end
      @(negedge clk); idle();
      #1 chk("drain_halted", halted, 1);
      chk("drain_cnt", stall_count, exp_cnt);
      set_lu(4'd5);
      #1 chk("halted_stalls", {if_stall_n, id_ex_stall_n, ex_mem_stall_n}, 0);
      chk("halted_flush", {if_id_flush, id_ex_flush, mem_wb_flush}, 0);
      repeat (2) @(negedge clk);
      #1 chk("halted_cnt_frozen", stall_count, exp_cnt);
      chk("halted_sticky", halted, 1);
      do_rst();

      // ---- halt drain extended by a 2-cycle memory wait ----
      @(negedge clk); id_halt = 1;
      exp_cnt++;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk); id_halt = 0; mem_req = (i <= 2);
         #1 chk($sformatf("dwait%0d_halted", i), halted, 0);
         if (i <= 2)
            chk($sformatf("dwait%0d_ctrl", i), {mem_wb_flush, id_ex_flush, id_ex_stall_n}, 3'b100);
         exp_cnt++;
      end
      @(negedge clk);
      #1 chk("dwait_halted", halted, 1);
      chk("dwait_cnt", stall_count, exp_cnt);
      do_rst();

      // ---- async reset mid-drain with stall_count = 7 ----
      @(negedge clk); set_lu(4'd7);
      repeat (4) @(negedge clk);
      idle(); id_halt = 1;
      repeat (3) @(negedge clk);
      id_halt = 0;
      #1 chk("mid_cnt", stall_count, 7);
      chk("mid_drain", {halted, if_stall_n}, 0);
      do_rst();
      @(negedge clk); id_branch_taken = 1;
      #1 chk("post_rst_branch", {if_id_flush, if_stall_n}, 2'b11);
      @(negedge clk); idle(); set_lu(4'd2);
      #1 chk("post_rst_lu", {if_stall_n, id_ex_flush}, 2'b01);
      @(negedge clk); idle();
      #1 chk("post_rst_cnt", stall_count, 1);
      do_rst();

      // ---- saturation (4-bit counter instance) ----
      @(negedge clk); set_lu(4'd4);
      repeat (15) @(negedge clk);
      #1 chk("sat_15", stall_count4, 15);
      repeat (5) @(negedge clk);
      #1 chk("sat_hold", stall_count4, 15);
      chk("sat_wide", stall_count, 20);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
